// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_pkg
//  Description : Shared types and constants for the ID/EX pipeline register.
//                This package provides:
//                  - the ALUOp encodings decoded by the ALU control block
//                  - the EX-side control bundle
//                  - the bubble control constant
//  Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    // ALUOp encodings decoded by the downstream ALU control block.
    localparam logic [1:0] c_aluop_rtype = 2'b00;  // decode via function field
    localparam logic [1:0] c_aluop_sub   = 2'b01;  // subtract / branch compare
    localparam logic [1:0] c_aluop_op111 = 2'b10;  // ALU operation 111
    localparam logic [1:0] c_aluop_add   = 2'b11;  // address add (lw/sw)

    // Control bundle carried through EX. The valid flag travels with the six
    // decoded control bits so that a bubble is a single constant assignment.
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic [1:0] aluop;
    } ctrl_t;

    // A bubble writes nothing. With ALUOp=00 and function=0, ALU control
    // selects op 000, which is harmless.
    localparam ctrl_t c_ctrl_bubble = '{
        valid    : 1'b0,
        regwrite : 1'b0,
        memtoreg : 1'b0,
        memread  : 1'b0,
        memwrite : 1'b0,
        alusrc   : 1'b0,
        regdst   : 1'b0,
        aluop    : c_aluop_rtype
    };

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard detection. A hazard exists
//                when all of the following hold:
//                  - EX holds a valid load
//                  - that load's destination (rt) is a source of the live
//                    instruction in ID
//                A branch flush kills the ID instruction, so it also masks
//                the hazard.
//  Ports       : i_ex_valid, i_ex_memread, i_ex_rt - instruction in EX
//                i_id_valid, i_id_rs, i_id_rt,
//                i_id_uses_rt                      - instruction in ID
//                i_flush                           - branch flush
//                o_hazard                          - load-use hazard
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect #(
    parameter int REG_W = 3
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_id_valid,
    input  logic             i_flush,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    output logic             o_hazard
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_ex_is_load;

    assign w_ex_is_load = i_ex_valid & i_ex_memread;
    assign w_rs_match   = (i_ex_rt == i_id_rs);

    // rt only counts as a dependency when the ID instruction reads it
    // (e.g. R-type or store data). It does not count when rt is a destination.
    assign w_rt_match   = i_id_uses_rt & (i_ex_rt == i_id_rt);

    assign o_hazard = w_ex_is_load & i_id_valid & ~i_flush & (w_rs_match | w_rt_match);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use hazard detection.
//                On each clock edge the stage does one of the following:
//                  - holds everything on a global stall
//                  - inserts a bubble on a branch flush or a load-use hazard
//                  - loads the ID instruction otherwise
//                It also counts load-use bubbles with a saturating counter.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                stall_i, flush_i      - global freeze, branch kill
//                id_*_i                - decoded instruction from ID
//                ex_*_o                - registered instruction to EX
//                hazard_o              - combinational load-use hazard
//                pc_write_o,
//                if_id_write_o         - upstream write enables
//                bubble_count_o        - saturating load-use bubble count
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int FUNC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic              id_regwrite_i,
    input  logic              id_memtoreg_i,
    input  logic              id_memread_i,
    input  logic              id_memwrite_i,
    input  logic              id_alusrc_i,
    input  logic              id_regdst_i,
    input  logic [1:0]        id_aluop_i,
    input  logic [FUNC_W-1:0] id_function_i,
    input  logic [DATA_W-1:0] id_rd1_i,
    input  logic [DATA_W-1:0] id_rd2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_W-1:0]  id_rs_i,
    input  logic [REG_W-1:0]  id_rt_i,
    input  logic [REG_W-1:0]  id_rd_i,
    input  logic              id_uses_rt_i,
    output logic              ex_valid_o,
    output logic              ex_regwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_alusrc_o,
    output logic              ex_regdst_o,
    output logic [1:0]        ex_aluop_o,
    output logic [FUNC_W-1:0] ex_function_o,
    output logic [DATA_W-1:0] ex_rd1_o,
    output logic [DATA_W-1:0] ex_rd2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_W-1:0]  ex_rs_o,
    output logic [REG_W-1:0]  ex_rt_o,
    output logic [REG_W-1:0]  ex_rd_o,
    output logic              hazard_o,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic [CNT_W-1:0]  bubble_count_o
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    ctrl_t             r_ctrl;
    logic [FUNC_W-1:0] r_function;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_hazard;
    logic              w_bubble;
    logic              w_cnt_sat;
    ctrl_t             w_id_ctrl;

    // ------------------------------------------------------------------
    // Hazard detection against the instruction currently held in EX
    // ------------------------------------------------------------------
    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .i_ex_valid   (r_ctrl.valid),
        .i_ex_memread (r_ctrl.memread),
        .i_ex_rt      (r_rt),
        .i_id_valid   (id_valid_i),
        .i_flush      (flush_i),
        .i_id_rs      (id_rs_i),
        .i_id_rt      (id_rt_i),
        .i_id_uses_rt (id_uses_rt_i),
        .o_hazard     (w_hazard)
    );

    // Flush already masks w_hazard, so a flush-induced bubble is never counted.
    assign w_bubble  = flush_i | w_hazard;
    assign w_cnt_sat = &r_bubble_count;

    // An invalid ID slot carries no control, even if the decoder
    // produced stray bits for it.
    always_comb begin
        w_id_ctrl = c_ctrl_bubble;
        if (id_valid_i) begin
            w_id_ctrl.valid    = 1'b1;
            w_id_ctrl.regwrite = id_regwrite_i;
            w_id_ctrl.memtoreg = id_memtoreg_i;
            w_id_ctrl.memread  = id_memread_i;
            w_id_ctrl.memwrite = id_memwrite_i;
            w_id_ctrl.alusrc   = id_alusrc_i;
            w_id_ctrl.regdst   = id_regdst_i;
            w_id_ctrl.aluop    = id_aluop_i;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register: stall > bubble (flush or hazard) > load
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl         <= c_ctrl_bubble;
            r_function     <= '0;
            r_rd1          <= '0;
            r_rd2          <= '0;
            r_imm          <= '0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_rd           <= '0;
            r_bubble_count <= '0;
        end else if (!stall_i) begin
            if (w_bubble) begin
                r_ctrl     <= c_ctrl_bubble;
                r_function <= '0;
            end else begin
                r_ctrl     <= w_id_ctrl;
                r_function <= id_function_i;
            end
            // Data and addresses are don't-care under a bubble. They are
            // loaded unconditionally to keep the datapath mux-free.
            r_rd1 <= id_rd1_i;
            r_rd2 <= id_rd2_i;
            r_imm <= id_imm_i;
            r_rs  <= id_rs_i;
            r_rt  <= id_rt_i;
            r_rd  <= id_rd_i;
            if (w_hazard && !w_cnt_sat) begin
                r_bubble_count <= r_bubble_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_valid_o     = r_ctrl.valid;
    assign ex_regwrite_o  = r_ctrl.regwrite;
    assign ex_memtoreg_o  = r_ctrl.memtoreg;
    assign ex_memread_o   = r_ctrl.memread;
    assign ex_memwrite_o  = r_ctrl.memwrite;
    assign ex_alusrc_o    = r_ctrl.alusrc;
    assign ex_regdst_o    = r_ctrl.regdst;
    assign ex_aluop_o     = r_ctrl.aluop;
    assign ex_function_o  = r_function;
    assign ex_rd1_o       = r_rd1;
    assign ex_rd2_o       = r_rd2;
    assign ex_imm_o       = r_imm;
    assign ex_rs_o        = r_rs;
    assign ex_rt_o        = r_rt;
    assign ex_rd_o        = r_rd;
    assign bubble_count_o = r_bubble_count;

    assign hazard_o      = w_hazard;
    assign pc_write_o    = ~(w_hazard | stall_i);
    assign if_id_write_o = ~(w_hazard | stall_i);

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. The stimulus consists
//                of directed scenarios followed by randomized traffic. The
//                reference model keeps the expected EX-stage contents as a
//                plain record. It also keeps a saturating bubble count.
//                A narrow counter width keeps saturation reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int FUNC_W = 4;
    localparam int CNT_W  = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall_i, flush_i, id_valid_i;
    logic              id_regwrite_i, id_memtoreg_i, id_memread_i;
    logic              id_memwrite_i, id_alusrc_i, id_regdst_i;
    logic [1:0]        id_aluop_i;
    logic [FUNC_W-1:0] id_function_i;
    logic [DATA_W-1:0] id_rd1_i, id_rd2_i, id_imm_i;
    logic [REG_W-1:0]  id_rs_i, id_rt_i, id_rd_i;
    logic              id_uses_rt_i;
    logic              ex_valid_o, ex_regwrite_o, ex_memtoreg_o, ex_memread_o;
    logic              ex_memwrite_o, ex_alusrc_o, ex_regdst_o;
    logic [1:0]        ex_aluop_o;
    logic [FUNC_W-1:0] ex_function_o;
    logic [DATA_W-1:0] ex_rd1_o, ex_rd2_o, ex_imm_o;
    logic [REG_W-1:0]  ex_rs_o, ex_rt_o, ex_rd_o;
    logic              hazard_o, pc_write_o, if_id_write_o;
    logic [CNT_W-1:0]  bubble_count_o;

    always #5 clk = ~clk;

    id_ex_stage #(
        .DATA_W (DATA_W), .REG_W (REG_W), .FUNC_W (FUNC_W), .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),            .rst_n          (rst_n),
        .stall_i        (stall_i),        .flush_i        (flush_i),
        .id_valid_i     (id_valid_i),     .id_regwrite_i  (id_regwrite_i),
        .id_memtoreg_i  (id_memtoreg_i),  .id_memread_i   (id_memread_i),
        .id_memwrite_i  (id_memwrite_i),  .id_alusrc_i    (id_alusrc_i),
        .id_regdst_i    (id_regdst_i),    .id_aluop_i     (id_aluop_i),
        .id_function_i  (id_function_i),  .id_rd1_i       (id_rd1_i),
        .id_rd2_i       (id_rd2_i),       .id_imm_i       (id_imm_i),
        .id_rs_i        (id_rs_i),        .id_rt_i        (id_rt_i),
        .id_rd_i        (id_rd_i),        .id_uses_rt_i   (id_uses_rt_i),
        .ex_valid_o     (ex_valid_o),     .ex_regwrite_o  (ex_regwrite_o),
        .ex_memtoreg_o  (ex_memtoreg_o),  .ex_memread_o   (ex_memread_o),
        .ex_memwrite_o  (ex_memwrite_o),  .ex_alusrc_o    (ex_alusrc_o),
        .ex_regdst_o    (ex_regdst_o),    .ex_aluop_o     (ex_aluop_o),
        .ex_function_o  (ex_function_o),  .ex_rd1_o       (ex_rd1_o),
        .ex_rd2_o       (ex_rd2_o),       .ex_imm_o       (ex_imm_o),
        .ex_rs_o        (ex_rs_o),        .ex_rt_o        (ex_rt_o),
        .ex_rd_o        (ex_rd_o),        .hazard_o       (hazard_o),
        .pc_write_o     (pc_write_o),     .if_id_write_o  (if_id_write_o),
        .bubble_count_o (bubble_count_o)
    );

    // ------------------------------------------------------------------
    // Reference model: contents of the EX slot as a plain record
    // ------------------------------------------------------------------
    typedef struct {
        bit     valid, regwrite, memtoreg, memread, memwrite, alusrc, regdst;
        int     aluop, func, rd1, rd2, imm, rs, rt, rd;
    } ex_slot_t;

    ex_slot_t m_ex;
    int       m_count;
    int       n_cmp = 0;
    int       n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ex    = '{default: 0};
        m_count = 0;
    endfunction

    // A load in EX blocks any live ID instruction reading its destination.
    // A flush kills the ID instruction and so removes the dependency.
    function automatic bit model_hazard();
        bit dep;
        dep = (m_ex.rt == int'(id_rs_i)) || (id_uses_rt_i && m_ex.rt == int'(id_rt_i));
        return m_ex.valid && m_ex.memread && id_valid_i && !flush_i && dep;
    endfunction

    function automatic void model_edge();
        bit hz;
        hz = model_hazard();
        if (stall_i) return;
        m_ex.rd1 = id_rd1_i; m_ex.rd2 = id_rd2_i; m_ex.imm = id_imm_i;
        m_ex.rs  = id_rs_i;  m_ex.rt  = id_rt_i;  m_ex.rd  = id_rd_i;
        m_ex.func = id_function_i;
        if (flush_i || hz || !id_valid_i) begin
            m_ex.valid = 0; m_ex.regwrite = 0; m_ex.memtoreg = 0; m_ex.memread = 0;
            m_ex.memwrite = 0; m_ex.alusrc = 0; m_ex.regdst = 0; m_ex.aluop = 0;
            if (flush_i || hz) m_ex.func = 0;
        end else begin
            m_ex.valid = 1; m_ex.regwrite = id_regwrite_i; m_ex.memtoreg = id_memtoreg_i;
            m_ex.memread = id_memread_i; m_ex.memwrite = id_memwrite_i;
            m_ex.alusrc = id_alusrc_i; m_ex.regdst = id_regdst_i; m_ex.aluop = id_aluop_i;
        end
        if (hz && m_count < CNT_MAX) m_count++;
    endfunction

    task automatic compare_ex(input string tag);
        check({tag, ".valid"},    32'(ex_valid_o),    32'(m_ex.valid));
        check({tag, ".regwrite"}, 32'(ex_regwrite_o), 32'(m_ex.regwrite));
        check({tag, ".memtoreg"}, 32'(ex_memtoreg_o), 32'(m_ex.memtoreg));
        check({tag, ".memread"},  32'(ex_memread_o),  32'(m_ex.memread));
        check({tag, ".memwrite"}, 32'(ex_memwrite_o), 32'(m_ex.memwrite));
        check({tag, ".alusrc"},   32'(ex_alusrc_o),   32'(m_ex.alusrc));
        check({tag, ".regdst"},   32'(ex_regdst_o),   32'(m_ex.regdst));
        check({tag, ".aluop"},    32'(ex_aluop_o),    32'(m_ex.aluop));
        check({tag, ".count"},    32'(bubble_count_o), 32'(m_count));
        if (m_ex.valid) begin
            check({tag, ".func"}, 32'(ex_function_o), 32'(m_ex.func));
            check({tag, ".rd1"},  32'(ex_rd1_o), 32'(m_ex.rd1));
            check({tag, ".rd2"},  32'(ex_rd2_o), 32'(m_ex.rd2));
            check({tag, ".imm"},  32'(ex_imm_o), 32'(m_ex.imm));
            check({tag, ".rs"},   32'(ex_rs_o),  32'(m_ex.rs));
            check({tag, ".rt"},   32'(ex_rt_o),  32'(m_ex.rt));
            check({tag, ".rd"},   32'(ex_rd_o),  32'(m_ex.rd));
        end else if (!stall_i) begin
            // A bubble must carry function 0000 as well.
            check({tag, ".bfunc"}, 32'(ex_function_o), 32'(m_ex.func));
        end
    endtask

    // One clock: check the combinational outputs with the current inputs,
    // advance the model, then compare registered outputs after the edge.
    task automatic tick(input string tag);
        bit hz;
        #1;
        hz = model_hazard();
        check({tag, ".hazard"},   32'(hazard_o),      32'(hz));
        check({tag, ".pc_write"}, 32'(pc_write_o),    32'(!(hz || stall_i)));
        check({tag, ".ifid_wr"},  32'(if_id_write_o), 32'(!(hz || stall_i)));
        @(posedge clk);
        model_edge();
        #1;
        compare_ex(tag);
    endtask

    task automatic set_id(input bit v, input bit rw, input bit m2r, input bit mr,
                          input bit mw, input bit as, input bit rdst, input int aop,
                          input int fn, input int d1, input int rs, input int rt,
                          input int urt);
        id_valid_i = v; id_regwrite_i = rw; id_memtoreg_i = m2r; id_memread_i = mr;
        id_memwrite_i = mw; id_alusrc_i = as; id_regdst_i = rdst;
        id_aluop_i = 2'(aop); id_function_i = FUNC_W'(fn);
        id_rd1_i = DATA_W'(d1); id_rd2_i = DATA_W'(d1 ^ 16'h5A5A);
        id_imm_i = DATA_W'(d1 + 7);
        id_rs_i = REG_W'(rs); id_rt_i = REG_W'(rt); id_rd_i = REG_W'(rs + rt);
        id_uses_rt_i = urt;
    endtask

    // lw rt=3 (base rs=1), and add rd <- rs, rt
    task automatic set_lw3();   set_id(1,1,1,1,0,1,0,3,0,16'h0100,1,3,0); endtask

    task automatic set_rand();
        set_id($urandom_range(3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(3)),
               int'($urandom_range(15)), int'($urandom_range(16'hFFFF)),
               int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(1)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctrl"}, 32'({ex_valid_o, ex_regwrite_o, ex_memtoreg_o, ex_memread_o,
                                   ex_memwrite_o, ex_alusrc_o, ex_regdst_o, ex_aluop_o}), 32'd0);
        check({tag, ".func"}, 32'(ex_function_o), 32'd0);
        check({tag, ".data"}, 32'({ex_rd1_o | ex_rd2_o | ex_imm_o}), 32'd0);
        check({tag, ".addr"}, 32'({ex_rs_o, ex_rt_o, ex_rd_o}), 32'd0);
        check({tag, ".count"}, 32'(bubble_count_o), 32'd0);
        check({tag, ".hazard"}, 32'(hazard_o), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 0; flush_i = 0;
        set_id(0,0,0,0,0,0,0,0,0,0,0,0,0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset.pc_write", 32'(pc_write_o), 32'd1);
        rst_n = 1'b1;

        // R-type add: ALUOp=00, function=0010, rd1=0x1234
        set_id(1,1,0,0,0,0,1,0,4'b0010,16'h1234,1,2,1);
        tick("rtype");
        check("rtype.aluop_k", 32'(ex_aluop_o), 32'd0);
        check("rtype.func_k",  32'(ex_function_o), 32'h2);
        check("rtype.rd1_k",   32'(ex_rd1_o), 32'h1234);
        check("rtype.valid_k", 32'(ex_valid_o), 32'd1);

        // Load-use through rs: exactly one counted bubble, then the consumer
        set_lw3();
        tick("lu_lw");
        set_id(1,1,0,0,0,0,1,0,4'b0010,16'h2222,3,4,1);
        #1;
        check("lu.hazard_k",   32'(hazard_o), 32'd1);
        check("lu.pc_write_k", 32'(pc_write_o), 32'd0);
        tick("lu_bubble");
        check("lu.bubble_valid_k", 32'(ex_valid_o), 32'd0);
        check("lu.count_k",        32'(bubble_count_o), 32'd1);
        tick("lu_consumer");
        check("lu.consumer_rs_k",  32'(ex_rs_o), 32'd3);
        check("lu.consumer_vld_k", 32'(ex_valid_o), 32'd1);

        // rt matches but is not a source operand: no hazard
        set_lw3();
        tick("nrt_lw");
        set_id(1,1,0,0,0,1,0,3,0,16'h3333,5,3,0);
        tick("nrt_use");
        check("nrt.valid_k", 32'(ex_valid_o), 32'd1);

        // Flush masks the hazard: uncounted bubble, enables stay high
        set_lw3();
        tick("fl_lw");
        set_id(1,1,0,0,0,0,1,0,1,16'h4444,3,3,1);
        flush_i = 1;
        #1;
        check("fl.ifid_k", 32'(if_id_write_o), 32'd1);
        tick("fl_bubble");
        check("fl.count_k", 32'(bubble_count_o), 32'd1);
        flush_i = 0;

        // Stall with flush held: frozen for 3 edges, then a bubble
        set_lw3();
        tick("st_lw");
        flush_i = 1; stall_i = 1;
        set_id(1,1,0,0,0,0,1,0,5,16'h5555,6,7,1);
        for (int i = 0; i < 3; i++) tick("st_hold");
        check("st.hold_valid_k", 32'(ex_valid_o), 32'd1);
        stall_i = 0;
        tick("st_release");
        check("st.release_valid_k", 32'(ex_valid_o), 32'd0);
        flush_i = 0;

        // Back-to-back dependent loads drive the counter into saturation
        set_id(1,1,1,1,0,1,0,3,0,16'h0600,3,3,1);
        for (int i = 0; i < 2 * CNT_MAX + 8; i++) tick("sat");
        check("sat.count_k", 32'(bubble_count_o), 32'(CNT_MAX));

        // Reset asserted mid-cycle while a hazard is pending
        set_lw3();
        tick("rst_lw");
        set_id(1,1,0,0,0,0,1,0,2,16'h7777,3,0,0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic with occasional stalls and flushes
        for (int i = 0; i < 600; i++) begin
            set_rand();
            stall_i = ($urandom_range(7) == 0);
            flush_i = ($urandom_range(7) == 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
